// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals shared by mem_arbiter and its environment.
// master = requesters plus memory (drives requests and mem_rdata); slave = the arbiter.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic [31:0]           p0_addr;
  logic                  p0_rsp_valid;
  logic [DATA_WIDTH-1:0] p0_rsp_rdata;

  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic [31:0]           p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_we;
  logic                  p1_lock;
  logic                  p1_rsp_valid;
  logic [DATA_WIDTH-1:0] p1_rsp_rdata;

  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rw;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output p0_req_valid, p0_addr,
    output p1_req_valid, p1_addr, p1_wdata, p1_we, p1_lock,
    output mem_rdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    input  mem_addr, mem_wdata, mem_rw
  );

  modport slave (
    input  p0_req_valid, p0_addr,
    input  p1_req_valid, p1_addr, p1_wdata, p1_we, p1_lock,
    input  mem_rdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    output mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port async-read memory: p1 (load/store, lockable) has priority,
// p0 (fetch) is force-granted after MAX_WAIT denials. Optional grant counters under MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]  stat_p0_grants,
  output logic [31:0]  stat_p1_grants,
  output logic [15:0]  stat_p0_forced
`endif
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  p0_rsp_valid_q, p0_rsp_valid_d;
  logic                  p1_rsp_valid_q, p1_rsp_valid_d;
  logic [DATA_WIDTH-1:0] p0_rsp_rdata_q, p0_rsp_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rsp_rdata_q, p1_rsp_rdata_d;

  logic p0Grant;
  logic p1Grant;
  logic p0Forced;
  logic starved;

  assign starved = (wait_cnt_q >= MaxWait);

  // Grants are gated by reset_n itself so the memory is released the instant reset asserts.
  always_comb begin
    state_d  = state_q;
    p0Grant  = 1'b0;
    p1Grant  = 1'b0;
    p0Forced = 1'b0;
    if (reset_n) begin
      case (state_q)
        ARB: begin
          if (bus.p0_req_valid && bus.p1_req_valid) begin
            if (starved) begin
              p0Grant  = 1'b1;
              p0Forced = 1'b1;
            end else begin
              p1Grant  = 1'b1;
            end
          end else begin
            p0Grant = bus.p0_req_valid;
            p1Grant = bus.p1_req_valid;
          end
          if (p1Grant && bus.p1_lock) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          p1Grant = bus.p1_req_valid;
          // Dropping lock releases ownership whether or not p1 is issuing its final access.
          if (!bus.p1_lock) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = 4'd0;
    if (bus.p0_req_valid && !p0Grant) begin
      wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    p0_rsp_valid_d = p0Grant;
    p1_rsp_valid_d = p1Grant;
    p0_rsp_rdata_d = p0_rsp_rdata_q;
    p1_rsp_rdata_d = p1_rsp_rdata_q;
    if (p0Grant) begin
      p0_rsp_rdata_d = bus.mem_rdata;
    end
    if (p1Grant) begin
      p1_rsp_rdata_d = bus.p1_we ? '0 : bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB;
      wait_cnt_q     <= 4'd0;
      p0_rsp_valid_q <= 1'b0;
      p1_rsp_valid_q <= 1'b0;
      p0_rsp_rdata_q <= '0;
      p1_rsp_rdata_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      p0_rsp_valid_q <= p0_rsp_valid_d;
      p1_rsp_valid_q <= p1_rsp_valid_d;
      p0_rsp_rdata_q <= p0_rsp_rdata_d;
      p1_rsp_rdata_q <= p1_rsp_rdata_d;
    end
  end

  assign bus.p0_req_ready = p0Grant;
  assign bus.p1_req_ready = p1Grant;
  assign bus.mem_addr     = p1Grant ? bus.p1_addr : (p0Grant ? bus.p0_addr : 32'd0);
  assign bus.mem_wdata    = bus.p1_wdata;
  assign bus.mem_rw       = p1Grant && bus.p1_we;
  assign bus.p0_rsp_valid = p0_rsp_valid_q;
  assign bus.p1_rsp_valid = p1_rsp_valid_q;
  assign bus.p0_rsp_rdata = p0_rsp_rdata_q;
  assign bus.p1_rsp_rdata = p1_rsp_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_p0_grants_q;
  logic [31:0] stat_p1_grants_q;
  logic [15:0] stat_p0_forced_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_p0_grants_q <= 32'd0;
      stat_p1_grants_q <= 32'd0;
      stat_p0_forced_q <= 16'd0;
    end else begin
      if (p0Grant)  stat_p0_grants_q <= stat_p0_grants_q + 32'd1;
      if (p1Grant)  stat_p1_grants_q <= stat_p1_grants_q + 32'd1;
      if (p0Forced) stat_p0_forced_q <= stat_p0_forced_q + 16'd1;
    end
  end

  assign stat_p0_grants = stat_p0_grants_q;
  assign stat_p1_grants = stat_p1_grants_q;
  assign stat_p0_forced = stat_p0_forced_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the arbitration rules and a shadow memory.
module tb_mem_arbiter;
  localparam int DW        = 32;
  localparam int MAXW      = 4;
  localparam int MEM_WORDS = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] statP0Grants;
  logic [31:0] statP1Grants;
  logic [15:0] statP0Forced;
`endif

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_p0_grants (statP0Grants),
    .stat_p1_grants (statP1Grants),
    .stat_p0_forced (statP0Forced)
`endif
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  function automatic logic [DW-1:0] initWord(int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 32'hDEADBEEF;
    return {8'hC3, b, b ^ 8'h5A, ~b};
  endfunction

  // Environment memory: async read, write commits at the clock edge of the grant.
  logic [DW-1:0] mem [MEM_WORDS];
  logic          preloadEn = 1'b0;
  logic [5:0]    preloadIdx = '0;
  logic [DW-1:0] preloadData = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (preloadEn) mem[preloadIdx] <= preloadData;
    else if (bus.mem_rw) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic p0v, input logic [31:0] p0a,
                               input logic p1v, input logic [31:0] p1a,
                               input logic [DW-1:0] p1wd, input logic p1we, input logic p1lk);
    @(posedge clk);
    #1;
    bus.p0_req_valid = p0v;
    bus.p0_addr      = p0a;
    bus.p1_req_valid = p1v;
    bus.p1_addr      = p1a;
    bus.p1_wdata     = p1wd;
    bus.p1_we        = p1we;
    bus.p1_lock      = p1lk;
  endtask

  // Reference model: who owns the memory, how long p0 has waited, and what each port is owed next.
  logic          modelInit = 1'b0;
  logic [DW-1:0] modelMem [MEM_WORDS];
  bit            mLocked;
  int            mWait;
  bit            expP0Valid, expP1Valid;
  logic [DW-1:0] expP0Data, expP1Data;
  logic [31:0]   mP0Grants, mP1Grants;
  logic [15:0]   mP0Forced;

  always @(negedge clk) begin
    int who;
    int idx;
    if (!modelInit) begin
      for (int i = 0; i < MEM_WORDS; i++) modelMem[i] = initWord(i);
      modelInit = 1'b1;
    end
    if (!reset_n) begin
      checkOutput("rst_p0_ready", bus.p0_req_ready, 0);
      checkOutput("rst_p1_ready", bus.p1_req_ready, 0);
      checkOutput("rst_mem_rw", bus.mem_rw, 0);
      checkOutput("rst_mem_addr", bus.mem_addr, 0);
      checkOutput("rst_p0_rsp_valid", bus.p0_rsp_valid, 0);
      checkOutput("rst_p1_rsp_valid", bus.p1_rsp_valid, 0);
      checkOutput("rst_p0_rsp_rdata", bus.p0_rsp_rdata, 0);
      checkOutput("rst_p1_rsp_rdata", bus.p1_rsp_rdata, 0);
      mLocked = 0; mWait = 0;
      expP0Valid = 0; expP1Valid = 0; expP0Data = '0; expP1Data = '0;
      mP0Grants = '0; mP1Grants = '0; mP0Forced = '0;
    end else begin
      if (mLocked) who = bus.p1_req_valid ? 1 : -1;
      else if (bus.p0_req_valid && bus.p1_req_valid) who = (mWait >= MAXW) ? 0 : 1;
      else if (bus.p1_req_valid) who = 1;
      else if (bus.p0_req_valid) who = 0;
      else who = -1;

      checkOutput("p0_req_ready", bus.p0_req_ready, (who == 0));
      checkOutput("p1_req_ready", bus.p1_req_ready, (who == 1));
      checkOutput("mem_addr", bus.mem_addr, (who == 1) ? bus.p1_addr : (who == 0) ? bus.p0_addr : 0);
      checkOutput("mem_rw", bus.mem_rw, (who == 1) && bus.p1_we);
      checkOutput("mem_wdata", bus.mem_wdata, bus.p1_wdata);
      checkOutput("p0_rsp_valid", bus.p0_rsp_valid, expP0Valid);
      checkOutput("p1_rsp_valid", bus.p1_rsp_valid, expP1Valid);
      checkOutput("p0_rsp_rdata", bus.p0_rsp_rdata, expP0Data);
      checkOutput("p1_rsp_rdata", bus.p1_rsp_rdata, expP1Data);
`ifdef MEM_ARB_STATS_EN
      checkOutput("stat_p0_grants", statP0Grants, mP0Grants);
      checkOutput("stat_p1_grants", statP1Grants, mP1Grants);
      checkOutput("stat_p0_forced", statP0Forced, mP0Forced);
`endif

      expP0Valid = (who == 0);
      expP1Valid = (who == 1);
      if (who == 0) begin
        expP0Data = modelMem[bus.p0_addr[7:2]];
        mP0Grants++;
        if (bus.p1_req_valid) mP0Forced++;
      end
      if (who == 1) begin
        idx = int'(bus.p1_addr[7:2]);
        expP1Data = bus.p1_we ? '0 : modelMem[idx];
        if (bus.p1_we) modelMem[idx] = bus.p1_wdata;
        mP1Grants++;
        mLocked = bus.p1_lock;
      end else if (mLocked && !bus.p1_lock) begin
        mLocked = 0;
      end
      if (bus.p0_req_valid && who != 0) mWait = (mWait + 1 > MAXW) ? MAXW : mWait + 1;
      else mWait = 0;
    end
  end

  initial begin
    logic hold0, hold1;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] s0g, s1g;
    logic [15:0] sf;
`endif
    bus.p0_req_valid = 0; bus.p0_addr = '0;
    bus.p1_req_valid = 0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_we = 0; bus.p1_lock = 0;

    for (int i = 0; i < MEM_WORDS; i++) begin
      @(posedge clk);
      #1;
      preloadEn = 1'b1; preloadIdx = 6'(i); preloadData = initWord(i);
    end
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
    checkOutput("reset_p0_ready_lit", bus.p0_req_ready, 0);
    reset_n = 1'b1;

    // Fetch read of preloaded word 4.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s1_p0_ready", bus.p0_req_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s1_p0_rsp_valid", bus.p0_rsp_valid, 1);
    checkOutput("s1_p0_rsp_rdata", bus.p0_rsp_rdata, 32'hDEADBEEF);
    checkOutput("s1_p1_rsp_valid", bus.p1_rsp_valid, 0);

    // Store then load to the same address on consecutive cycles.
    applyStimulus(0, 0, 1, 32'h20, 32'h12345678, 1, 0);
    #1;
    checkOutput("s2_mem_rw", bus.mem_rw, 1);
    applyStimulus(0, 0, 1, 32'h20, 32'h0, 0, 0);
    #1;
    checkOutput("s2_ack_valid", bus.p1_rsp_valid, 1);
    checkOutput("s2_ack_rdata", bus.p1_rsp_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s2_rd_valid", bus.p1_rsp_valid, 1);
    checkOutput("s2_rd_rdata", bus.p1_rsp_rdata, 32'h12345678);
`ifdef MEM_ARB_STATS_EN
    s0g = statP0Grants; s1g = statP1Grants; sf = statP0Forced;
`endif

    // Both ports held valid: p1 wins four cycles, then p0 is forced.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 32'h30, 1, 32'h34, 32'h0, 0, 0);
      #1;
      checkOutput($sformatf("s3_p1_ready_c%0d", k), bus.p1_req_ready, (k % 5) != 4);
      checkOutput($sformatf("s3_p0_ready_c%0d", k), bus.p0_req_ready, (k % 5) == 4);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef MEM_ARB_STATS_EN
    checkOutput("s3_stat_forced", 64'(statP0Forced - sf), 2);
    checkOutput("s3_stat_p0", 64'(statP0Grants - s0g), 2);
    checkOutput("s3_stat_p1", 64'(statP1Grants - s1g), 10);
`endif

    // Locked read-modify-write holds p0 off until the unlocking write.
    applyStimulus(1, 32'h40, 1, 32'h44, 32'h0, 0, 1);
    #1;
    checkOutput("s4_lock_p1_ready", bus.p1_req_ready, 1);
    checkOutput("s4_lock_p0_ready", bus.p0_req_ready, 0);
    applyStimulus(1, 32'h40, 1, 32'h44, 32'hA5A5A5A5, 1, 0);
    #1;
    checkOutput("s4_unlock_p1_ready", bus.p1_req_ready, 1);
    checkOutput("s4_unlock_p0_ready", bus.p0_req_ready, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s4_after_p0_ready", bus.p0_req_ready, 1);

    // Reset during a locked p1 read grant.
    applyStimulus(0, 0, 1, 32'h48, 32'h0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_p1_ready_drop", bus.p1_req_ready, 0);
    checkOutput("s5_mem_rw", bus.mem_rw, 0);
    checkOutput("s5_mem_addr", bus.mem_addr, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s5_no_pulse_in_reset", bus.p1_rsp_valid, 0);
    reset_n = 1'b1;
    applyStimulus(1, 32'h0C, 0, 0, 0, 0, 0);
    #1;
    checkOutput("s5_no_pulse_after", bus.p1_rsp_valid, 0);
    checkOutput("s5_state_arb", bus.p0_req_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; a request not yet granted keeps its fields.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold0 = bus.p0_req_valid && !bus.p0_req_ready;
      hold1 = bus.p1_req_valid && !bus.p1_req_ready;
      @(posedge clk);
      #1;
      if (!hold0) begin
        bus.p0_req_valid = ($urandom_range(0, 9) < 6);
        bus.p0_addr      = {24'h0, 6'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
      end
      if (!hold1) begin
        bus.p1_req_valid = ($urandom_range(0, 9) < 6);
        bus.p1_addr      = {24'h0, 6'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
        bus.p1_wdata     = $urandom;
        bus.p1_we        = $urandom_range(0, 1) == 1;
        bus.p1_lock      = $urandom_range(0, 3) == 0;
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, word-addressed, asynchronous-read memory between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: load/store unit, read/write, with lock support for read-modify-write.
- Sits between the core pipeline and the memory; it alone drives the memory addr/wdata/mem_rw inputs.
- Grants at most one access per cycle, registers read data and returns a one-cycle response pulse to the winning port.
- Priority goes to port 1, with a starvation guard for port 0.

Parameters:
- DATA_WIDTH, 32, width of memory data and response data (equals `MEM_DATA_WIDTH).
- MAX_WAIT, 4, consecutive cycles port 0 may be denied before it is force-granted; range 1-15.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- p0_req_valid  in  1  fetch request
- p0_req_ready  out  1  fetch request granted this cycle
- p0_addr  in  32  fetch byte address
- p0_rsp_valid  out  1  fetch response pulse
- p0_rsp_rdata  out  DATA_WIDTH  fetch read data
- p1_req_valid  in  1  data request
- p1_req_ready  out  1  data request granted this cycle
- p1_addr  in  32  data byte address
- p1_wdata  in  DATA_WIDTH  store data
- p1_we  in  1  1 = write, 0 = read
- p1_lock  in  1  hold exclusive ownership after this grant
- p1_rsp_valid  out  1  data response pulse
- p1_rsp_rdata  out  DATA_WIDTH  load data; 0 for write acks
- mem_addr  out  32  to memory addr
- mem_wdata  out  DATA_WIDTH  to memory wdata
- mem_rw  out  1  to memory mem_rw (1 = write)
- mem_rdata  in  DATA_WIDTH  from memory rdata (combinational)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: state = ARB, wait_cnt = 0, rsp_valid both 0, rsp_rdata both 0.
  - While reset_n = 0: p0_req_ready = p1_req_ready = 0, mem_rw = 0, mem_addr = 0.
  - Reset asserted mid-transaction drops any pending response; no response is issued after release.
- Grant logic is combinational from the current state and inputs. A handshake completes when valid && ready in the same cycle.
- ARB state:
  - Only p0 valid: grant p0.
  - Only p1 valid: grant p1.
  - Both valid: grant p1, unless wait_cnt >= MAX_WAIT, in which case grant p0.
  - Neither valid: no grant.
- LOCKED state:
  - Only p1 can be granted; p0_req_ready = 0.
  - Starvation override is disabled.
- FSM transitions:
  - ARB -> LOCKED: p1 granted with p1_lock = 1.
  - LOCKED -> ARB: p1 granted with p1_lock = 0 (this is the final locked access), or p1_lock = 0 while p1_req_valid = 0.
  - LOCKED, p1 granted with p1_lock = 1: stay in LOCKED.
- wait_cnt (4-bit):
  - Increments, saturating at MAX_WAIT, on every cycle p0_req_valid = 1 and p0 is not granted, including in LOCKED.
  - Clears to 0 on a p0 grant, or when p0_req_valid = 0.
- Memory drive:
  - mem_addr is the granted port's address; 0 when there is no grant.
  - mem_wdata = p1_wdata always.
  - mem_rw = p1 granted && p1_we; never 1 without a p1 grant.
- Response, fixed 1-cycle latency:
  - On the edge after a grant, the granted port's rsp_valid = 1 for exactly one cycle.
  - rsp_rdata captures mem_rdata from the grant cycle for reads, and 0 for writes.
  - rsp_rdata holds its value until the next response on that port.
  - The non-granted port's rsp_valid = 0.
  - Back-to-back grants produce back-to-back pulses.
- Ordering:
  - Write followed by read to the same address on consecutive cycles returns the new data, because the memory write commits at the grant edge.
  - Responses are never reordered within a port.
- Requesters must hold addr/wdata/we/lock stable while valid && !ready. The arbiter does not check this.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, add outputs:
  - stat_p0_grants (32 bits): wrapping count of p0 grants.
  - stat_p1_grants (32 bits): wrapping count of p1 grants.
  - stat_p0_forced (16 bits): wrapping count of p0 grants won by the starvation override.
- All three reset to 0 and update one cycle after each grant.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Preload mem[4] = 32'hDEADBEEF; p0 reads addr 32'h10 alone -> p0_req_ready = 1 that cycle; next cycle p0_rsp_valid = 1, p0_rsp_rdata = 32'hDEADBEEF; p1_rsp_valid = 0.
- p1 writes 32'h12345678 to addr 32'h20, then reads 32'h20 in the next cycle -> write ack pulse with rdata 0, then read pulse with rdata 32'h12345678.
- p0 and p1 both held valid for 12 cycles with MAX_WAIT = 4 -> p1 granted cycles 0-3, p0 force-granted cycle 4, pattern repeats.
- p1 read with lock = 1, then write with lock = 0, while p0 is valid throughout -> p0_req_ready = 0 for both p1 cycles; p0 granted in the following cycle.
- Assert reset_n = 0 asynchronously mid-cycle immediately after a p1 read grant -> p1_rsp_valid never pulses, mem_rw = 0 immediately, state returns to ARB.
- With MEM_ARB_STATS_EN: run scenario 3 -> stat_p0_forced = 2, stat_p0_grants = 2, stat_p1_grants = 10.
